// File: rtl/clint_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clint_pkg
// Brief   : Shared constants, response-state type and byte-strobe merge for
//           the core-local interruptor.
// Revision: 1.0 - initial release
// ============================================================================
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MTIME_RST    = 64'h0000_0000_0000_0000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } resp_state_e;

  // Bytes with a clear strobe keep the value supplied in old_val.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  wstrb);
    logic [63:0] merged;
    merged = old_val;
    for (int i = 0; i < 8; i++) begin
      if (wstrb[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clint_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : clint_prescaler
// Brief   : Divides clk by TICK_DIV and emits a one-cycle tick for mtime.
// Revision: 1.0 - initial release
// ============================================================================
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] c_last_cnt = 16'(TICK_DIV - 1);

  logic [15:0] r_cnt;

  assign tick = (r_cnt == c_last_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 16'd0;
    end else if (tick) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clint.sv
`default_nettype none
// ============================================================================
// Module  : clint
// Brief   : Memory-mapped machine timer, timer compare and software-interrupt
//           bit with a single-outstanding valid/ready bus slave.
// Revision: 1.0 - initial release
// ============================================================================
module clint #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mtip,
  output logic        msip_o
);

  import clint_pkg::*;

  logic        w_tick;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  resp_state_e r_state;
  resp_state_e w_state_nxt;
  logic [63:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic [15:0] w_addr_al;
  logic        w_sel_msip;
  logic        w_sel_cmp;
  logic        w_sel_time;
  logic        w_mapped;
  logic [63:0] w_mtime_inc;
  logic [63:0] w_mtime_nxt;
  logic [63:0] w_cmp_nxt;
  logic        w_msip_nxt;
  logic [63:0] w_rdata_nxt;
  logic        w_err_nxt;
  logic        w_unused;

  clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_unused   = ^req_addr[2:0];
  assign w_addr_al  = {req_addr[15:3], 3'b000};
  assign w_sel_msip = (w_addr_al == CLINT_MSIP_OFF);
  assign w_sel_cmp  = (w_addr_al == CLINT_MTIMECMP_OFF);
  assign w_sel_time = (w_addr_al == CLINT_MTIME_OFF);
  assign w_mapped   = w_sel_msip | w_sel_cmp | w_sel_time;

  assign resp_valid = (r_state == ST_RESP);
  assign req_ready  = !resp_valid || resp_ready;
  assign w_accept   = req_valid && req_ready;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mtip       = (r_mtime >= r_mtimecmp);
  assign msip_o     = r_msip;

  // The merge starts from the incremented time so a partial write in a tick
  // cycle keeps the tick in the untouched bytes.
  assign w_mtime_inc = w_tick ? (r_mtime + 64'd1) : r_mtime;

  always_comb begin
    w_mtime_nxt = w_mtime_inc;
    w_cmp_nxt   = r_mtimecmp;
    w_msip_nxt  = r_msip;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    if (w_accept) begin
      w_err_nxt   = !w_mapped;
      w_rdata_nxt = 64'd0;
      if (req_we) begin
        if (w_sel_time) begin
          w_mtime_nxt = strb_merge(w_mtime_inc, req_wdata, req_wstrb);
        end
        if (w_sel_cmp) begin
          w_cmp_nxt = strb_merge(r_mtimecmp, req_wdata, req_wstrb);
        end
        if (w_sel_msip && req_wstrb[0]) begin
          w_msip_nxt = req_wdata[0];
        end
      end else begin
        if (w_sel_time) begin
          w_rdata_nxt = r_mtime;
        end else if (w_sel_cmp) begin
          w_rdata_nxt = r_mtimecmp;
        end else if (w_sel_msip) begin
          w_rdata_nxt = {63'd0, r_msip};
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_accept) begin
          w_state_nxt = ST_RESP;
        end else if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime    <= MTIME_RST;
      r_mtimecmp <= MTIMECMP_RST;
      r_msip     <= 1'b0;
      r_state    <= ST_IDLE;
      r_rdata    <= 64'd0;
      r_err      <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_cmp_nxt;
      r_msip     <= w_msip_nxt;
      r_state    <= w_state_nxt;
      r_rdata    <= w_rdata_nxt;
      r_err      <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clint.sv
`default_nettype none
// ============================================================================
// Module  : tb_clint
// Brief   : Directed self-checking bench for clint (TICK_DIV = 1 and 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_clint;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_we, resp_ready;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        req_ready, resp_valid, resp_err, mtip, msip_o;
  logic [63:0] resp_rdata;

  logic        req_valid4, req_we4, resp_ready4;
  logic [15:0] req_addr4;
  logic [63:0] req_wdata4;
  logic [7:0]  req_wstrb4;
  logic        req_ready4, resp_valid4, resp_err4, mtip4, msip_o4;
  logic [63:0] resp_rdata4;

  int total = 0;
  int bad   = 0;

  logic [63:0] got_rdata;
  logic        got_err;
  logic        got_valid;

  always #5 clk = ~clk;

  clint #(.TICK_DIV(1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mtip       (mtip),
    .msip_o     (msip_o)
  );

  clint #(.TICK_DIV(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid4),
    .req_ready  (req_ready4),
    .req_we     (req_we4),
    .req_addr   (req_addr4),
    .req_wdata  (req_wdata4),
    .req_wstrb  (req_wstrb4),
    .resp_valid (resp_valid4),
    .resp_ready (resp_ready4),
    .resp_rdata (resp_rdata4),
    .resp_err   (resp_err4),
    .mtip       (mtip4),
    .msip_o     (msip_o4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request on u_dut, accepted at the next edge; response captured after it.
  task automatic bus(input logic we, input logic [15:0] addr,
                     input logic [63:0] wd, input logic [7:0] st);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = st;
    step();
    req_valid = 1'b0;
    req_we    = 1'b0;
    got_rdata = resp_rdata;
    got_err   = resp_err;
    got_valid = resp_valid;
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0; req_we  = 1'b0; req_addr  = 16'h0;
    req_wdata   = 64'h0; req_wstrb = 8'h0; resp_ready = 1'b1;
    req_valid4  = 1'b0; req_we4 = 1'b0; req_addr4 = 16'h0;
    req_wdata4  = 64'h0; req_wstrb4 = 8'h0; resp_ready4 = 1'b1;

    repeat (3) step();
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err",   {63'd0, resp_err}, 64'd0);
    check("rst_mtip",       {63'd0, mtip}, 64'd0);
    check("rst_msip",       {63'd0, msip_o}, 64'd0);
    check("rst_req_ready",  {63'd0, req_ready}, 64'd1);
    rst = 1'b0;

    // Prescaler, TICK_DIV = 4: mtime = floor(edges/4) after release.
    repeat (39) step();
    req_valid4 = 1'b1;
    req_addr4  = 16'hBFF8;
    step();
    check("pre_mtime_39", resp_rdata4, 64'd9);
    step();
    check("pre_mtime_40", resp_rdata4, 64'd10);
    req_valid4 = 1'b0;

    // Timer firing.
    bus(1'b1, 16'hBFF8, 64'd0, 8'hFF);
    check("tmr_wr_valid", {63'd0, got_valid}, 64'd1);
    check("tmr_mtip_a", {63'd0, mtip}, 64'd0);
    bus(1'b1, 16'h4000, 64'd10, 8'hFF);
    check("tmr_wr_rdata", got_rdata, 64'd0);
    repeat (8) step();
    check("tmr_mtip_at9", {63'd0, mtip}, 64'd0);
    step();
    check("tmr_mtip_at10", {63'd0, mtip}, 64'd1);
    bus(1'b0, 16'hBFF8, 64'd0, 8'h00);
    check("tmr_read_ge10", {63'd0, (got_rdata >= 64'd10)}, 64'd1);
    check("tmr_read_val", got_rdata, 64'd10);

    // Software interrupt.
    bus(1'b1, 16'h0000, 64'd1, 8'h01);
    check("sw_set", {63'd0, msip_o}, 64'd1);
    bus(1'b0, 16'h0000, 64'd0, 8'h00);
    check("sw_read", got_rdata, 64'd1);
    bus(1'b1, 16'h0000, 64'd0, 8'h00);
    check("sw_nostrb", {63'd0, msip_o}, 64'd1);
    bus(1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFE, 8'h01);
    check("sw_clear", {63'd0, msip_o}, 64'd0);

    // Wrap.
    bus(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    bus(1'b0, 16'hBFF8, 64'd0, 8'h00);
    check("wrap_fe", got_rdata, 64'hFFFF_FFFF_FFFF_FFFE);
    bus(1'b0, 16'hBFF8, 64'd0, 8'h00);
    check("wrap_ff", got_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    bus(1'b0, 16'hBFF8, 64'd0, 8'h00);
    check("wrap_0", got_rdata, 64'd0);

    // Collision of bus write and tick.
    bus(1'b1, 16'hBFF8, 64'd5, 8'hFF);
    bus(1'b0, 16'hBFF8, 64'd0, 8'h00);
    check("coll_full", got_rdata, 64'd5);
    bus(1'b1, 16'hBFF8, 64'h00FF, 8'hFF);
    bus(1'b1, 16'hBFF8, 64'h1200, 8'h02);
    bus(1'b0, 16'hBFF8, 64'd0, 8'h00);
    check("coll_partial", got_rdata, 64'h1200);

    // Strobed mtimecmp write.
    bus(1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'hFF);
    bus(1'b1, 16'h4000, 64'hAABB_CCDD_EEFF_0011, 8'hF0);
    bus(1'b0, 16'h4000, 64'd0, 8'h00);
    check("cmp_strb", got_rdata, 64'hAABB_CCDD_5566_7788);

    // Backpressure: response held, next request stalled.
    resp_ready = 1'b0;
    req_valid  = 1'b1; req_we = 1'b0; req_addr = 16'h4000;
    step();
    req_we = 1'b1; req_addr = 16'h0000; req_wdata = 64'd1; req_wstrb = 8'h01;
    for (int i = 0; i < 3; i++) begin
      check("bp_req_ready", {63'd0, req_ready}, 64'd0);
      check("bp_valid", {63'd0, resp_valid}, 64'd1);
      check("bp_rdata", resp_rdata, 64'hAABB_CCDD_5566_7788);
      check("bp_msip_hold", {63'd0, msip_o}, 64'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    req_valid = 1'b0; req_we = 1'b0;
    check("bp_next_valid", {63'd0, resp_valid}, 64'd1);
    check("bp_next_rdata", resp_rdata, 64'd0);
    check("bp_next_msip", {63'd0, msip_o}, 64'd1);
    step();
    check("bp_drain", {63'd0, resp_valid}, 64'd0);

    // Unmapped and ignored address bits.
    bus(1'b0, 16'h1000, 64'd0, 8'h00);
    check("err_rd_data", got_rdata, 64'd0);
    check("err_rd_err", {63'd0, got_err}, 64'd1);
    bus(1'b1, 16'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    check("err_wr_err", {63'd0, got_err}, 64'd1);
    bus(1'b0, 16'h4005, 64'd0, 8'h00);
    check("err_cmp_kept", got_rdata, 64'hAABB_CCDD_5566_7788);
    check("err_ok", {63'd0, got_err}, 64'd0);
    bus(1'b0, 16'h0000, 64'd0, 8'h00);
    check("err_msip_kept", got_rdata, 64'd1);

    // Reset while a response is pending.
    bus(1'b1, 16'h4000, 64'd0, 8'hFF);
    check("pre_rst_mtip", {63'd0, mtip}, 64'd1);
    resp_ready = 1'b0;
    bus(1'b0, 16'hBFF8, 64'd0, 8'h00);
    check("pre_rst_valid", {63'd0, resp_valid}, 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, resp_valid}, 64'd0);
    check("arst_rdata", resp_rdata, 64'd0);
    check("arst_err",   {63'd0, resp_err}, 64'd0);
    check("arst_mtip",  {63'd0, mtip}, 64'd0);
    check("arst_msip",  {63'd0, msip_o}, 64'd0);
    check("arst_ready", {63'd0, req_ready}, 64'd1);
    step();
    step();
    rst = 1'b0;
    resp_ready = 1'b1;
    step();
    check("post_rst_noresp", {63'd0, resp_valid}, 64'd0);
    bus(1'b0, 16'hBFF8, 64'd0, 8'h00);
    check("post_rst_mtime", got_rdata, 64'd1);
    check("post_rst_valid", {63'd0, got_valid}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
